// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
//
// Pipelined WIDTH-bit add/subtract unit built from 4-bit carry look-ahead
// groups. Each pipeline stage evaluates GROUPS_PER_STAGE groups. Inside a
// stage the carry ripples from group to group. The carry out of a stage is
// registered for the next stage. Upper operand slices travel forward in
// skew registers. Finished lower sum slices travel forward in alignment
// registers. The handshake is valid/ready with full backpressure and
// sustains one beat per cycle.
//
// Latency: LAT = ceil((WIDTH/4) / GROUPS_PER_STAGE) cycles from accept to
// out_valid.
//
// Optional build macro: CLA_PIPE_SAT_EN. When it is defined, the module
// adds a "sat" input. When sat=1 and the result overflows, sum is clamped
// to the signed extreme.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand beat valid
//   in_ready   stage 0 can accept a beat (combinational from out_ready)
//   a, b       operands, WIDTH bits
//   carry_in   carry in (borrow chain on subtract)
//   sub        0 = add, 1 = subtract
//   sat        (CLA_PIPE_SAT_EN only) clamp sum on signed overflow
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result, WIDTH bits
//   carry_out  carry from the MSB group (1 = no borrow on subtract)
//   overflow   two's-complement signed overflow
// -----------------------------------------------------------------------------
module cla_pipe_addsub #(
   parameter int WIDTH            = 16,
   parameter int GROUPS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NG  = WIDTH / 4;
   localparam int GPS = GROUPS_PER_STAGE;
   localparam int LAT = (NG + GPS - 1) / GPS;

   localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and at least 4");
   end
   if (GROUPS_PER_STAGE < 1) begin : g_bad_gps
      $error("cla_pipe_addsub: GROUPS_PER_STAGE must be at least 1");
   end

   // One 4-bit look-ahead group. Generate is a&b and propagate is a|b, so
   // the sum bits must use a^b rather than p.
   function automatic logic [4:0] cla4(input logic [3:0] x,
                                       input logic [3:0] y,
                                       input logic       c0);
      logic [3:0] g, p;
      logic       c1, c2, c3, c4;
      g  = x & y;
      p  = x | y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c4, x ^ y ^ {c3, c2, c1, c0}};
   endfunction

   // The clamp direction follows the sign of a. Signed overflow only happens
   // when both addends share that sign.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s,
                                                 input logic             a_neg,
                                                 input logic             clamp);
      if (!clamp)
         return s;
      return a_neg ? MIN_NEG : MAX_POS;
   endfunction

   logic                 sat_i;
`ifdef CLA_PIPE_SAT_EN
   assign sat_i = sat;
`else
   assign sat_i = 1'b0;
`endif

   // Control: stage valid bits, load enables, and incoming valid per stage.
   logic [LAT-1:0]   vld_p;
   logic [LAT-1:0]   ld;
   logic [LAT-1:0]   vin;

   // Skew/alignment registers between stages (entry k = output of stage k).
   logic [WIDTH-1:0] a_p   [LAT];
   logic [WIDTH-1:0] b_p   [LAT];
   logic [WIDTH-1:0] s_p   [LAT];
   logic             c_p   [LAT];
   logic             sat_p [LAT];

   // Per-stage inputs (muxed from ports or previous stage) and next values.
   logic [WIDTH-1:0] a_in  [LAT];
   logic [WIDTH-1:0] b_in  [LAT];
   logic [WIDTH-1:0] s_in  [LAT];
   logic             c_in  [LAT];
   logic             sat_in[LAT];
   logic [WIDTH-1:0] a_n   [LAT];
   logic [WIDTH-1:0] b_n   [LAT];
   logic [WIDTH-1:0] s_n   [LAT];
   logic             c_n   [LAT];
   logic             sat_n [LAT];

   logic             ovf_n;
   logic [WIDTH-1:0] sum_n;

   logic [WIDTH-1:0] sum_r;
   logic             co_r;
   logic             ovf_r;

   // A stage may load when it is empty or when the stage after it loads.
   // The chain ends at out_ready, so a full pipe still accepts a new beat
   // in the same cycle that the last stage is emitted.
   always_comb begin
      logic acc;
      acc = out_ready;
      for (int k = LAT - 1; k >= 0; k--) begin
         acc   = !vld_p[k] || acc;
         ld[k] = acc;
      end
   end

   assign in_ready = ld[0];

   always_comb begin
      vin[0] = in_valid;
      for (int k = 1; k < LAT; k++)
         vin[k] = vld_p[k-1];
   end

   always_comb begin
      a_in[0]   = a;
      b_in[0]   = b ^ {WIDTH{sub}};
      c_in[0]   = carry_in ^ sub;
      s_in[0]   = '0;
      sat_in[0] = sat_i;
      for (int k = 1; k < LAT; k++) begin
         a_in[k]   = a_p[k-1];
         b_in[k]   = b_p[k-1];
         c_in[k]   = c_p[k-1];
         s_in[k]   = s_p[k-1];
         sat_in[k] = sat_p[k-1];
      end
   end

   // Each stage covers groups k*GPS upward. The last stage may hold fewer
   // groups than GPS.
   always_comb begin
      for (int k = 0; k < LAT; k++) begin
         logic [WIDTH-1:0] si;
         logic             ci;
         logic [4:0]       grp;
         int               gi;
         si  = s_in[k];
         ci  = c_in[k];
         grp = '0;
         gi  = 0;
         for (int j = 0; j < GPS; j++) begin
            gi = k * GPS + j;
            if (gi < NG) begin
               grp            = cla4(a_in[k][4*gi +: 4], b_in[k][4*gi +: 4], ci);
               si[4*gi +: 4]  = grp[3:0];
               ci             = grp[4];
            end
         end
         a_n[k]   = a_in[k];
         b_n[k]   = b_in[k];
         s_n[k]   = si;
         c_n[k]   = ci;
         sat_n[k] = sat_in[k];
      end
   end

   always_comb begin
      ovf_n = (a_n[LAT-1][WIDTH-1] == b_n[LAT-1][WIDTH-1]) &&
              (s_n[LAT-1][WIDTH-1] != a_n[LAT-1][WIDTH-1]);
      sum_n = saturate(s_n[LAT-1], a_n[LAT-1][WIDTH-1], sat_n[LAT-1] && ovf_n);
   end

   // ---- stage boundaries: valid bits and output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
         sum_r <= '0;
         co_r  <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         for (int k = 0; k < LAT; k++)
            if (ld[k])
               vld_p[k] <= vin[k];
         if (ld[LAT-1] && vin[LAT-1]) begin
            sum_r <= sum_n;
            co_r  <= c_n[LAT-1];
            ovf_r <= ovf_n;
         end
      end
   end

   // ---- stage boundaries: skew/alignment data (no reset needed) ----
   always_ff @(posedge clk) begin
      for (int k = 0; k < LAT - 1; k++) begin
         if (ld[k] && vin[k]) begin
            a_p[k]   <= a_n[k];
            b_p[k]   <= b_n[k];
            s_p[k]   <= s_n[k];
            c_p[k]   <= c_n[k];
            sat_p[k] <= sat_n[k];
         end
      end
   end

   assign out_valid = vld_p[LAT-1];
   assign sum       = sum_r;
   assign carry_out = co_r;
   assign overflow  = ovf_r;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_addsub
//
// Directed bench for cla_pipe_addsub with WIDTH=16 and GROUPS_PER_STAGE=1
// (LAT=4). It covers reset, add/subtract vectors, wrap and overflow
// boundaries, backpressure with back-to-back beats, and a mid-stream reset.
// It also runs a random stream checked against a reference model. The
// saturation cases are included when CLA_PIPE_SAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_cla_pipe_addsub;

   localparam int W   = 16;
   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         sub;
`ifdef CLA_PIPE_SAT_EN
   logic         sat;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cla_pipe_addsub #(.WIDTH(W), .GROUPS_PER_STAGE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sub       (sub),
`ifdef CLA_PIPE_SAT_EN
      .sat       (sat),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   // Sends one beat into an empty pipe with out_ready high. It returns the
   // captured result and the number of clock edges from accept to out_valid.
   task automatic run_beat(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tcin, input logic tsub,
                           output logic [W-1:0] s, output logic co,
                           output logic ov, output int lat);
      @(negedge clk);
      a = ta; b = tb_; carry_in = tcin; sub = tsub;
      in_valid = 1'b1; out_ready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 20);
      s = sum; co = carry_out; ov = overflow;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
`ifdef CLA_PIPE_SAT_EN
      sat = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
      checks++; if ({carry_out, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {carry_out, overflow}); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_add;
      logic [W-1:0] s; logic co, ov; int lat;
      run_beat(16'h1234, 16'h0FED, 1'b0, 1'b0, s, co, ov, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL add_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (s !== 16'h2221) begin errors++; $display("FAIL add_sum: got %h expected 2221", s); end
      checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b expected 00", {co, ov}); end
   endtask

   task automatic test_sub;
      logic [W-1:0] s; logic co, ov; int lat;
      run_beat(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov, lat);
      checks++; if (s !== 16'hFFFE) begin errors++; $display("FAIL sub_sum: got %h expected fffe", s); end
      checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL sub_flags: got %b expected 00", {co, ov}); end
      run_beat(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, ov, lat);
      checks++; if (s !== 16'hFFFD) begin errors++; $display("FAIL sub_borrow_sum: got %h expected fffd", s); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL sub_latency: got %0d expected %0d", lat, LAT); end
   endtask

   task automatic test_boundaries;
      logic [W-1:0] s; logic co, ov; int lat;
      run_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL wrap_sum: got %h expected 0000", s); end
      checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL wrap_flags: got %b expected 10", {co, ov}); end
      run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
      checks++; if (s !== 16'h8000) begin errors++; $display("FAIL posovf_sum: got %h expected 8000", s); end
      checks++; if ({co, ov} !== 2'b01) begin errors++; $display("FAIL posovf_flags: got %b expected 01", {co, ov}); end
      run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
      checks++; if (s !== 16'h7FFF) begin errors++; $display("FAIL negovf_sum: got %h expected 7fff", s); end
      checks++; if ({co, ov} !== 2'b11) begin errors++; $display("FAIL negovf_flags: got %b expected 11", {co, ov}); end
   endtask

   task automatic test_back_to_back;
      int sent = 0, rcv = 0, stall = 0, cyc = 0;
      bit first = 1'b0, saw_block = 1'b0, prev_stall = 1'b0;
      logic [W-1:0] held = '0;
      logic exp_ready;
      while (rcv < 10 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (out_valid && !first) begin first = 1'b1; stall = 6; end
         out_ready = (stall == 0);
         if (stall > 0) stall--;
         in_valid = (sent < 10);
         a = W'(sent + 1); b = W'(sent + 1); carry_in = 1'b0; sub = 1'b0;
         #1;
         exp_ready = ((sent - rcv) < LAT) || out_ready;
         checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL b2b_in_ready: got %b expected %b (cycle %0d)", in_ready, exp_ready, cyc); end
         if (!in_ready) saw_block = 1'b1;
         if (prev_stall) begin
            checks++; if ({out_valid, sum} !== {1'b1, held}) begin errors++; $display("FAIL b2b_stall_hold: got %b/%h expected 1/%h", out_valid, sum, held); end
         end
         prev_stall = out_valid && !out_ready;
         held = sum;
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            checks++; if (sum !== W'(2 * (rcv + 1))) begin errors++; $display("FAIL b2b_result: got %h expected %h", sum, W'(2 * (rcv + 1))); end
            rcv++;
         end
      end
      checks++; if (rcv !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", rcv); end
      checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_backpressure: got in_ready never low, expected low while stalled"); end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_beat: got out_valid %b expected 0", out_valid); end
      end
   endtask

   task automatic test_reset_mid;
      bit seen = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = W'(16'h0100 + i); b = 16'h0001; carry_in = 1'b0; sub = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;          // in_valid stays high: it must be ignored in reset
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_ghost: got a beat emitted after reset, expected none"); end
   endtask

   task automatic test_random;
      logic [W+1:0] exp_q[$];
      logic [W+1:0] exp, got;
      logic [W-1:0] be;
      logic [W:0]   full;
      logic         ov;
      int sent = 0, rcv = 0, cyc = 0;
      localparam int N = 300;
      while ((sent < N || exp_q.size() != 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
         a = W'($urandom); b = W'($urandom);
         carry_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            got = {overflow, carry_out, sum};
            if (exp_q.size() == 0) begin
               checks++; errors++; $display("FAIL rand_unexpected: got %h expected no beat", got);
            end else begin
               exp = exp_q.pop_front();
               checks++; if (got !== exp) begin errors++; $display("FAIL rand_beat%0d: got %h expected %h", rcv, got, exp); end
            end
            rcv++;
         end
         if (in_valid && in_ready) begin
            be   = sub ? ~b : b;
            full = {1'b0, a} + {1'b0, be} + (W+1)'(carry_in ^ sub);
            ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
            exp_q.push_back({ov, full});
            sent++;
         end
      end
      checks++; if (rcv !== N) begin errors++; $display("FAIL rand_count: got %0d expected %0d", rcv, N); end
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

`ifdef CLA_PIPE_SAT_EN
   task automatic test_sat;
      logic [W-1:0] s; logic co, ov; int lat;
      sat = 1'b1;
      run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
      checks++; if ({s, ov} !== {16'h7FFF, 1'b1}) begin errors++; $display("FAIL sat_pos: got %h/%b expected 7fff/1", s, ov); end
      run_beat(16'h8000, 16'hFFFF, 1'b0, 1'b0, s, co, ov, lat);
      checks++; if ({s, co, ov} !== {16'h8000, 1'b1, 1'b1}) begin errors++; $display("FAIL sat_neg: got %h/%b/%b expected 8000/1/1", s, co, ov); end
      sat = 1'b0;
      run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
      checks++; if ({s, ov} !== {16'h8000, 1'b1}) begin errors++; $display("FAIL sat_off: got %h/%b expected 8000/1", s, ov); end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_boundaries();
      test_back_to_back();
      test_reset_mid();
`ifdef CLA_PIPE_SAT_EN
      test_sat();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised successor to the team's 4-bit carry look-ahead adder.
- WIDTH-bit add/subtract unit built from 4-bit CLA groups (generate g=a&b, propagate p=a|b, ripple between group carries inside a stage).
- Pipeline registers sit at every GROUPS_PER_STAGE group boundary, with a valid/ready handshake and full backpressure.
- Sits in the arithmetic datapath between the operand mux and the ALU result register; sustains one operation per cycle.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- GROUPS_PER_STAGE, 1, number of 4-bit CLA groups evaluated per pipeline stage; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage 0 can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry/borrow in.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- carry_out  out  1  carry from MSB group.
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Derived constants:
  - NG = WIDTH/4.
  - LAT = ceil(NG/GROUPS_PER_STAGE), the pipeline depth in stages.
- Arithmetic:
  - beff = b XOR {WIDTH{sub}}; cin_eff = carry_in XOR sub.
  - {carry_out, sum} = a + beff + cin_eff, computed modulo 2^(WIDTH+1).
  - sub=1, carry_in=0 gives a-b. sub=1, carry_in=1 gives a-b-1 (borrow chain).
  - On subtract, carry_out=1 means no borrow.
  - overflow = (a[MSB] == beff[MSB]) && (sum[MSB] != a[MSB]).
- Stage k (0..LAT-1):
  - Computes groups k*GROUPS_PER_STAGE upward using the registered carry from stage k-1; stage 0 uses cin_eff.
  - Upper operand slices are carried forward in skew registers.
  - Lower sum slices already produced are carried forward in alignment registers.
  - The last stage may hold fewer groups than GROUPS_PER_STAGE.
- Latency: a beat accepted on cycle t appears with out_valid=1 on cycle t+LAT, if out_ready is held high.
- Handshake, stage-level valid bits v[k]:
  - Stage k advances when !v[k+1] || advance[k+1]; for the last stage the condition is out_ready.
  - in_ready = !v[0] || advance[0]. This is combinational from out_ready through the chain, with no bubble insertion.
  - A beat transfers when in_valid && in_ready.
  - A stage that is not advancing holds all its data and v[k].
  - Throughput is 1 beat/cycle when out_ready stays high.
- Output stability:
  - out_valid=1 && out_ready=0 holds sum, carry_out and overflow stable until accepted.
  - out_valid is never withdrawn without acceptance.
- Reset:
  - rst=1 clears every v[k]. Result: out_valid=0; in_ready=1 the cycle after rst deasserts.
  - sum, carry_out and overflow reset to 0.
  - Skew/alignment data registers need not reset.
  - Reset mid-operation discards all in-flight beats; none is emitted afterwards.
  - in_valid is ignored while rst=1.
- Simultaneous accept and emit in the same cycle with a full pipe is legal; occupancy stays at LAT.
- Wrap-around:
  - 0xFFFF+1 gives sum=0, carry_out=1.
  - 0x7FFF+1 gives overflow=1.
- No internal state beyond the pipeline; beats never interact.

Optional Feature:
- Macro: CLA_PIPE_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the operands and carried through the pipe.
  - At the last stage, if sat=1 and overflow=1, sum is clamped: 0x7FF..F if a[MSB]=0, else 0x800..0.
  - overflow still reports 1; carry_out is unchanged.
- Undefined:
  - Port absent; sum is always the wrapped result.
  - Logic and latency are otherwise identical. Latency is LAT in both builds.

Test Plan:
- WIDTH=16, GPS=1 (LAT=4), out_ready=1: a=0x1234, b=0x0FED, add, cin=0 -> sum=0x2221, carry_out=0, overflow=0, exactly 4 cycles after accept.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, carry_out=0 (borrow), overflow=0. Same operands with cin=1 -> sum=0xFFFD.
- Boundaries:
  - 0xFFFF+0x0001 -> sum=0x0000, carry_out=1, overflow=0.
  - 0x7FFF+0x0001 -> sum=0x8000, overflow=1.
  - 0x8000-0x0001 -> sum=0x7FFF, overflow=1.
- Backpressure, back-to-back beats a=i, b=i for i=1..10:
  - Hold out_ready=0 for 6 cycles after the first result -> in_ready drops once 4 beats are in flight.
  - Results 2,4,...,20 emerge in order with no loss or duplication; sum stays stable while stalled.
- Reset mid-stream: rst pulsed for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle, none of the 3 beats ever emitted, in_ready=1.
- With CLA_PIPE_SAT_EN: a=0x7FFF, b=0x0001, sat=1 -> sum=0x7FFF, overflow=1. Same operands with sat=0 -> sum=0x8000. Sweep WIDTH=8/GPS=3 and WIDTH=32/GPS=2 against a reference model on 10k random beats.
